// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//   Program sequencer: program counter, writable program memory and a
//   registered fetch stage. Each cycle in RUN it loads mem[addr] into instr
//   and advances addr. It also supports stall, conditional jump,
//   halt-word detection and an end-of-memory policy. The fetched word feeds
//   the control decoder.
//
//   Optional feature macro: CALL_STACK_EN
//     When defined, a return stack (STACK_D entries) is added, together with
//     the call_valid / ret_valid inputs and the stk_err output.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        synchronous reset, active low
//   run          in   1        1: advance, 0: stall
//   jmp_valid    in   1        jump request (only honoured with run=1)
//   jmp_addr     in   ADDR_W   jump / call target
//   cond_en      in   1        1: jump only when cond_flag=1
//   cond_flag    in   1        jump condition
//   prog_we      in   1        program memory write strobe
//   prog_waddr   in   ADDR_W   program memory write address
//   prog_wdata   in   INSTR_W  program memory write data
//   addr         out  ADDR_W   current fetch address (PC)
//   instr        out  INSTR_W  registered fetched word
//   instr_valid  out  1        instr is valid for decode this cycle
//   call_valid   in   1        (CALL_STACK_EN) push addr+1, jump to jmp_addr
//   ret_valid    in   1        (CALL_STACK_EN) pop return address into addr
//   stk_err      out  1        (CALL_STACK_EN) stack overflow/underflow seen
//   halted       out  1        sequencer is in HALT
// -----------------------------------------------------------------------------
module prog_sequencer #(
    parameter int                 ADDR_W    = 5,
    parameter int                 INSTR_W   = 12,
    parameter logic [INSTR_W-1:0] HALT_CODE = {INSTR_W{1'b1}},
    parameter bit                 WRAP      = 1'b1
`ifdef CALL_STACK_EN
    ,
    parameter int                 STACK_D   = 4
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               jmp_valid,
    input  logic [ADDR_W-1:0]  jmp_addr,
    input  logic               cond_en,
    input  logic               cond_flag,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_waddr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic [ADDR_W-1:0]  addr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
`ifdef CALL_STACK_EN
    input  logic               call_valid,
    input  logic               ret_valid,
    output logic               stk_err,
`endif
    output logic               halted
);

    localparam int DEPTH = 2**ADDR_W;

    // S_LAST: the final word of a non-wrapping memory was just presented;
    // the next edge enters HALT unconditionally.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_HALT} state_t;

    state_t              state, state_nx;
    logic [INSTR_W-1:0]  mem [DEPTH];
    logic [INSTR_W-1:0]  fetch_word;
    logic                halt_word;
    logic                jump_taken;
    logic                redirect;
    logic                stk_fault;
    logic                at_end;
    logic                advance;
    logic [ADDR_W-1:0]   target;

    // Writes are allowed in every state. A read of the same address in the
    // same cycle sees the old word because the write lands at the edge.
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_waddr] <= prog_wdata;
    end

    assign fetch_word = mem[addr];
    assign halt_word  = (fetch_word == HALT_CODE);
    assign jump_taken = run && jmp_valid && (!cond_en || cond_flag);
    assign at_end     = &addr;

`ifdef CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [ADDR_W-1:0] stk [STACK_D];
    logic [SP_W-1:0]   sp;
    logic              do_call, do_ret, stk_full, stk_empty;
    logic [IDX_W-1:0]  push_idx, top_idx;

    // A call in the same cycle as a return wins; the return is dropped.
    assign do_call   = run && call_valid;
    assign do_ret    = run && ret_valid && !call_valid;
    assign stk_full  = (sp == SP_W'(STACK_D));
    assign stk_empty = (sp == '0);
    assign push_idx  = IDX_W'(sp);
    assign top_idx   = IDX_W'(sp - SP_W'(1));
    assign stk_fault = (do_call && stk_full) || (do_ret && stk_empty);

    // call/ret outrank a plain jump; a call targets jmp_addr like a jump.
    always_comb begin
        redirect = do_call || do_ret || jump_taken;
        target   = jmp_addr;
        if (do_ret)
            target = stk[top_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp      <= '0;
            stk_err <= 1'b0;
        end else if (advance) begin
            if (stk_fault) begin
                stk_err <= 1'b1;
            end else if (do_call) begin
                stk[push_idx] <= addr + ADDR_W'(1);
                sp            <= sp + SP_W'(1);
            end else if (do_ret) begin
                sp <= sp - SP_W'(1);
            end
        end
    end
`else
    assign stk_fault = 1'b0;
    assign redirect  = jump_taken;
    assign target    = jmp_addr;
`endif

    // A halt word outranks every redirect; the fetch slot is otherwise live.
    assign advance = (state == S_RUN) && run && !halt_word;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (run) state_nx = S_RUN;
            S_RUN: begin
                if (run) begin
                    if (halt_word || stk_fault)
                        state_nx = S_HALT;
                    else if (!redirect && at_end && !WRAP)
                        state_nx = S_LAST;
                end
            end
            S_LAST: state_nx = S_HALT;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_HALT;
        endcase
    end

    // Output logic
    always_comb begin
        halted = (state == S_HALT);
    end

    // Fetch datapath. A redirect discards the current fetch (one bubble).
    // Without WRAP the PC parks on the last address while that word is
    // presented; the FSM then moves to HALT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr        <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (advance && !stk_fault) begin
                if (redirect) begin
                    addr <= target;
                end else begin
                    instr       <= fetch_word;
                    instr_valid <= 1'b1;
                    if (WRAP || !at_end)
                        addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

    localparam int AW  = 5;
    localparam int IW  = 12;
    localparam int AWS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (ADDR_W=5, WRAP=1)
    logic          rst_n, run, jmp_valid, cond_en, cond_flag, prog_we;
    logic [AW-1:0] jmp_addr, prog_waddr, addr;
    logic [IW-1:0] prog_wdata, instr;
    logic          instr_valid, halted;
`ifdef CALL_STACK_EN
    logic          call_valid, ret_valid, stk_err;
`endif

    // small instances (ADDR_W=3), one wrapping and one halting at the end
    logic           rst_s, run_s, we_s;
    logic [AWS-1:0] waddr_s, addr_w, addr_e;
    logic [IW-1:0]  wdata_s, instr_w, instr_e;
    logic           vld_w, vld_e, halt_w, halt_e;
    logic           zero_s;
    logic [AWS-1:0] zaddr_s;

`ifdef CALL_STACK_EN
    prog_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .STACK_D(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .jmp_valid(jmp_valid),
        .jmp_addr(jmp_addr), .cond_en(cond_en), .cond_flag(cond_flag),
        .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
        .addr(addr), .instr(instr), .instr_valid(instr_valid),
        .call_valid(call_valid), .ret_valid(ret_valid), .stk_err(stk_err),
        .halted(halted)
    );
`else
    prog_sequencer #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .jmp_valid(jmp_valid),
        .jmp_addr(jmp_addr), .cond_en(cond_en), .cond_flag(cond_flag),
        .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
        .addr(addr), .instr(instr), .instr_valid(instr_valid),
        .halted(halted)
    );
`endif

    prog_sequencer #(.ADDR_W(AWS), .INSTR_W(IW), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_s), .run(run_s), .jmp_valid(zero_s),
        .jmp_addr(zaddr_s), .cond_en(zero_s), .cond_flag(zero_s),
        .prog_we(we_s), .prog_waddr(waddr_s), .prog_wdata(wdata_s),
        .addr(addr_w), .instr(instr_w), .instr_valid(vld_w),
`ifdef CALL_STACK_EN
        .call_valid(zero_s), .ret_valid(zero_s), .stk_err(),
`endif
        .halted(halt_w)
    );

    prog_sequencer #(.ADDR_W(AWS), .INSTR_W(IW), .WRAP(1'b0)) dut_end (
        .clk(clk), .rst_n(rst_s), .run(run_s), .jmp_valid(zero_s),
        .jmp_addr(zaddr_s), .cond_en(zero_s), .cond_flag(zero_s),
        .prog_we(we_s), .prog_waddr(waddr_s), .prog_wdata(wdata_s),
        .addr(addr_e), .instr(instr_e), .instr_valid(vld_e),
`ifdef CALL_STACK_EN
        .call_valid(zero_s), .ret_valid(zero_s), .stk_err(),
`endif
        .halted(halt_e)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // addr, instr, instr_valid, halted of the main instance
    task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] i,
                             input logic [31:0] v, input logic [31:0] h);
        check({tag, ".addr"},  32'(addr),        a);
        check({tag, ".instr"}, 32'(instr),       i);
        check({tag, ".valid"}, 32'(instr_valid), v);
        check({tag, ".halted"}, 32'(halted),     h);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] prog [13];

    initial begin
        prog = '{12'h001, 12'h002, 12'h004, 12'h808, 12'h010, 12'hFFF, 12'h000,
                 12'h000, 12'h000, 12'h000, 12'h0AA, 12'h0BB, 12'h000};
        rst_n = 1'b0; run = 1'b0; jmp_valid = 1'b0; cond_en = 1'b0; cond_flag = 1'b0;
        jmp_addr = '0; prog_we = 1'b0; prog_waddr = '0; prog_wdata = '0;
`ifdef CALL_STACK_EN
        call_valid = 1'b0; ret_valid = 1'b0;
`endif
        rst_s = 1'b0; run_s = 1'b0; we_s = 1'b0; waddr_s = '0; wdata_s = '0;
        zero_s = 1'b0; zaddr_s = '0;

        // load program while held in reset
        for (int i = 0; i < 13; i++) begin
            prog_we = 1'b1; prog_waddr = AW'(i); prog_wdata = prog[i];
            tick();
        end
        prog_we = 1'b0;
        check_out("reset", 0, 0, 0, 0);

        // T1: sequential fetch, word at N appears one cycle after addr==N
        rst_n = 1'b1; run = 1'b1;
        tick(); check_out("idle_to_run", 0, 0, 0, 0);
        tick(); check_out("t1_w0", 1, 'h001, 1, 0);
        tick(); check_out("t1_w1", 2, 'h002, 1, 0);

        // T2: stall two cycles at addr 2
        run = 1'b0;
        tick(); check_out("t2_stall0", 2, 'h002, 0, 0);
        tick(); check_out("t2_stall1", 2, 'h002, 0, 0);
        run = 1'b1;
        tick(); check_out("t2_resume", 3, 'h004, 1, 0);

        // T3: conditional jump not taken, then taken with a bubble
        jmp_valid = 1'b1; jmp_addr = 10; cond_en = 1'b1; cond_flag = 1'b0;
        tick(); check_out("t3_not_taken", 4, 'h808, 1, 0);
        cond_flag = 1'b1;
        tick(); check_out("t3_taken", 10, 'h808, 0, 0);
        jmp_valid = 1'b0; cond_en = 1'b0; cond_flag = 1'b0;
        tick(); check_out("t3_target", 11, 'h0AA, 1, 0);

        // same-cycle write/read of addr 11 returns the old word
        prog_we = 1'b1; prog_waddr = 11; prog_wdata = 12'h123;
        tick(); check_out("rw_old", 12, 'h0BB, 1, 0);
        prog_we = 1'b0; jmp_valid = 1'b1; jmp_addr = 11;
        tick(); check_out("jmp_uncond", 11, 'h0BB, 0, 0);
        jmp_valid = 1'b0;
        tick(); check_out("rw_new", 12, 'h123, 1, 0);

        // jump ignored while stalled
        run = 1'b0; jmp_valid = 1'b1; jmp_addr = 0;
        tick(); check_out("stall_jmp", 12, 'h123, 0, 0);

        // reset mid-run with a pending jump
        run = 1'b1; jmp_valid = 1'b1; jmp_addr = 7; rst_n = 1'b0;
        tick(); check_out("rst_mid", 0, 0, 0, 0);

        // T4: halt word at addr 5
        jmp_valid = 1'b0; rst_n = 1'b1;
        tick();
        jmp_valid = 1'b1; jmp_addr = 4;
        tick(); check_out("t4_jump", 4, 0, 0, 0);
        jmp_valid = 1'b0;
        tick(); check_out("t4_w4", 5, 'h010, 1, 0);
        tick(); check_out("t4_halt", 5, 'h010, 0, 1);
        jmp_valid = 1'b1; jmp_addr = 0;
        tick(); check_out("t4_sticky", 5, 'h010, 0, 1);
        jmp_valid = 1'b0; rst_n = 1'b0;
        tick(); check_out("t4_reset", 0, 0, 0, 0);

`ifdef CALL_STACK_EN
        // T6: nested calls/returns, then overflow on a 2-deep stack
        rst_n = 1'b1;
        tick();
        tick(); check_out("t6_w0", 1, 'h001, 1, 0);
        call_valid = 1'b1; jmp_addr = 3;
        tick(); check_out("t6_call1", 3, 'h001, 0, 0);
        jmp_addr = 6;
        tick(); check_out("t6_call2", 6, 'h001, 0, 0);
        call_valid = 1'b0; ret_valid = 1'b1;
        tick(); check_out("t6_ret1", 4, 'h001, 0, 0);
        tick(); check_out("t6_ret2", 2, 'h001, 0, 0);
        check("t6_err_clear", 32'(stk_err), 0);
        ret_valid = 1'b0; call_valid = 1'b1; jmp_addr = 8;
        tick(); check_out("t6_call3", 8, 'h001, 0, 0);
        jmp_addr = 9;
        tick(); check_out("t6_call4", 9, 'h001, 0, 0);
        tick(); check_out("t6_overflow", 9, 'h001, 0, 1);
        check("t6_stk_err", 32'(stk_err), 1);
        call_valid = 1'b0; rst_n = 1'b0;
        tick();
        check("t6_err_reset", 32'(stk_err), 0);
`endif

        // T5: 8-word memories, wrap vs. end-of-memory halt
        for (int i = 0; i < 8; i++) begin
            we_s = 1'b1; waddr_s = AWS'(i); wdata_s = IW'(32'h100 + i);
            tick();
        end
        we_s = 1'b0; rst_s = 1'b1; run_s = 1'b1;
        tick();
        check("t5_start_w", 32'(addr_w), 0);
        check("t5_start_e", 32'(addr_e), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("t5_wrap_instr%0d", k), 32'(instr_w), 32'h100 + k);
            check($sformatf("t5_wrap_addr%0d", k),  32'(addr_w), (k + 1) % 8);
            check($sformatf("t5_end_instr%0d", k),  32'(instr_e), 32'h100 + k);
            check($sformatf("t5_end_valid%0d", k),  32'(vld_e), 1);
            check($sformatf("t5_end_addr%0d", k),   32'(addr_e), (k == 7) ? 7 : k + 1);
            check($sformatf("t5_end_halted%0d", k), 32'(halt_e), 0);
        end
        tick();
        check("t5_wrap_again_instr", 32'(instr_w), 'h100);
        check("t5_wrap_again_addr",  32'(addr_w), 1);
        check("t5_wrap_not_halted",  32'(halt_w), 0);
        check("t5_end_halted",       32'(halt_e), 1);
        check("t5_end_valid_off",    32'(vld_e), 0);
        check("t5_end_addr",         32'(addr_e), 7);
        tick();
        check("t5_end_sticky",       32'(halt_e), 1);
        check("t5_end_addr_frozen",  32'(addr_e), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
